// File: rtl/ej32_mem_arb_if.sv
`default_nettype none
// ============================================================================
// ej32_mem_arb_if : core, host and memory-side signals of the eJ32 memory arbiter
// Rev 1.0
// ============================================================================
interface ej32_mem_arb_if #(
  parameter int AW = 17
) ();

  // Core master port
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [7:0]    c_rdata;
  logic          core_stall;

  // Host master port
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [7:0]    h_rdata;
  logic          h_hold;
  logic          h_own;

  // Memory port
  logic          m_cs;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  logic [7:0]    m_rdata;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, core_stall,
    input  h_req, h_we, h_addr, h_wdata, h_hold,
    output h_gnt, h_rvalid, h_rdata, h_own,
    output m_cs, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // Requester and memory view
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, core_stall,
    output h_req, h_we, h_addr, h_wdata, h_hold,
    input  h_gnt, h_rvalid, h_rdata, h_own,
    input  m_cs, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface
`default_nettype wire

// File: rtl/ej32_mem_arb.sv
`default_nettype none
// ============================================================================
// ej32_mem_arb : single byte-wide memory port shared by eJ32 core and host
// Rev 1.0
// ============================================================================
module ej32_mem_arb #(
  parameter int AW    = 17,
  parameter int BURST = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ej32_mem_arb_if.slave bus
);

  localparam int unsigned     CW        = $clog2(BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(BURST);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_C    = 2'd1,
    RD_H    = 2'd2
  } rd_own_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_burst_nxt;
  rd_own_t       r_rd_own;
  rd_own_t       w_rd_own_nxt;

  logic          w_c_gnt;
  logic          w_h_gnt;
  logic          w_m_we;
  logic [AW-1:0] w_m_addr;
  logic [7:0]    w_m_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_burst_cnt <= '0;
      r_rd_own    <= RD_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rd_own    <= w_rd_own_nxt;
    end
  end

  // Grant decision and next state; reset suppresses every grant in its cycle.
  always_comb begin
    w_c_gnt     = 1'b0;
    w_h_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      case (r_state)
        ST_ARB: begin
          if (bus.h_hold) begin
            w_h_gnt     = bus.h_req;
            w_state_nxt = ST_HOLD;
          end else if (bus.c_req && bus.h_req) begin
            if (r_burst_cnt < BURST_MAX) begin
              w_h_gnt = 1'b1;
            end else begin
              w_c_gnt = 1'b1;
            end
          end else begin
            w_c_gnt = bus.c_req;
            w_h_gnt = bus.h_req;
          end
        end
        ST_HOLD: begin
          w_h_gnt = bus.h_req;
          if (!bus.h_hold) begin
            w_state_nxt = ST_ARB;
          end
        end
        default: begin
          w_state_nxt = ST_ARB;
        end
      endcase
    end
  end

  // Counts host grants the core has waited through; saturates so the core slot is guaranteed.
  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (w_c_gnt || !bus.c_req) begin
      w_burst_nxt = '0;
    end else if (w_h_gnt && (r_burst_cnt < BURST_MAX)) begin
      w_burst_nxt = r_burst_cnt + CW'(1);
    end
  end

  always_comb begin
    w_rd_own_nxt = RD_NONE;
    if (w_c_gnt && !bus.c_we) begin
      w_rd_own_nxt = RD_C;
    end else if (w_h_gnt && !bus.h_we) begin
      w_rd_own_nxt = RD_H;
    end
  end

  always_comb begin
    w_m_we    = 1'b0;
    w_m_addr  = '0;
    w_m_wdata = '0;
    if (w_c_gnt) begin
      w_m_we    = bus.c_we;
      w_m_addr  = bus.c_addr;
      w_m_wdata = bus.c_wdata;
    end else if (w_h_gnt) begin
      w_m_we    = bus.h_we;
      w_m_addr  = bus.h_addr;
      w_m_wdata = bus.h_wdata;
    end
  end

  assign bus.c_gnt      = w_c_gnt;
  assign bus.h_gnt      = w_h_gnt;
  assign bus.core_stall = bus.c_req & ~w_c_gnt & ~rst;
  assign bus.h_own      = (r_state == ST_HOLD);

  assign bus.m_cs       = w_c_gnt | w_h_gnt;
  assign bus.m_we       = w_m_we;
  assign bus.m_addr     = w_m_addr;
  assign bus.m_wdata    = w_m_wdata;

  // Read data is shared by both masters; rvalid tells each one whether it is theirs.
  assign bus.c_rvalid   = (r_rd_own == RD_C);
  assign bus.h_rvalid   = (r_rd_own == RD_H);
  assign bus.c_rdata    = rst ? 8'h00 : bus.m_rdata;
  assign bus.h_rdata    = rst ? 8'h00 : bus.m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ej32_mem_arb.sv
`default_nettype none
// ============================================================================
// tb_ej32_mem_arb : directed self-checking bench for ej32_mem_arb
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ej32_mem_arb;

  localparam int AW    = 17;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] mem [0:(1<<AW)-1];

  ej32_mem_arb_if #(.AW(AW)) bus ();

  ej32_mem_arb #(.AW(AW), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle registered read
  always @(posedge clk) begin
    if (bus.m_cs) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata     <= mem[bus.m_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.h_hold = 1'b0;
  endtask

  task automatic test_reset();
    bus.c_req = 1'b1; bus.h_req = 1'b1;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_c_gnt got %b want 0", bus.c_gnt); end
    n_checks++; if (bus.h_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_h_gnt got %b want 0", bus.h_gnt); end
    n_checks++; if (bus.m_cs !== 1'b0) begin n_fail++; $display("FAIL reset_m_cs got %b want 0", bus.m_cs); end
    n_checks++; if (bus.h_own !== 1'b0) begin n_fail++; $display("FAIL reset_h_own got %b want 0", bus.h_own); end
    n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.core_stall); end
    n_checks++; if ({bus.c_rvalid, bus.h_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {bus.c_rvalid, bus.h_rvalid}); end
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.h_gnt !== 1'b1) begin n_fail++; $display("FAIL release_h_gnt got %b want 1", bus.h_gnt); end
    n_checks++; if (bus.c_gnt !== 1'b0) begin n_fail++; $display("FAIL release_c_gnt got %b want 0", bus.c_gnt); end
    n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL release_stall got %b want 1", bus.core_stall); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_core_read();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 17'h01000;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL cread_gnt got %b want 1", bus.c_gnt); end
    n_checks++; if (bus.m_addr !== 17'h01000) begin n_fail++; $display("FAIL cread_m_addr got %h want 01000", bus.m_addr); end
    n_checks++; if ({bus.m_cs, bus.m_we} !== 2'b10) begin n_fail++; $display("FAIL cread_m_cs_we got %b want 10", {bus.m_cs, bus.m_we}); end
    step();
    bus.c_req = 1'b0;
    #1;
    n_checks++; if (bus.c_rvalid !== 1'b1) begin n_fail++; $display("FAIL cread_rvalid got %b want 1", bus.c_rvalid); end
    n_checks++; if (bus.c_rdata !== 8'h5A) begin n_fail++; $display("FAIL cread_rdata got %h want 5a", bus.c_rdata); end
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL cread_h_rvalid got %b want 0", bus.h_rvalid); end
    step();
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL cread_rvalid_drop got %b want 0", bus.c_rvalid); end
  endtask

  task automatic test_contention();
    logic prev_h;
    prev_h = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 17'h00010;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 17'h00020;
    for (int i = 0; i < 15; i++) begin
      logic exp_c;
      exp_c = ((i % 5) == 4);
      #1;
      n_checks++; if (bus.c_gnt !== exp_c) begin n_fail++; $display("FAIL contend_c_gnt slot %0d got %b want %b", i, bus.c_gnt, exp_c); end
      n_checks++; if (bus.h_gnt !== !exp_c) begin n_fail++; $display("FAIL contend_h_gnt slot %0d got %b want %b", i, bus.h_gnt, !exp_c); end
      n_checks++; if (bus.core_stall !== !exp_c) begin n_fail++; $display("FAIL contend_stall slot %0d got %b want %b", i, bus.core_stall, !exp_c); end
      n_checks++; if (bus.h_rvalid !== prev_h) begin n_fail++; $display("FAIL contend_h_rvalid slot %0d got %b want %b", i, bus.h_rvalid, prev_h); end
      prev_h = !exp_c;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_hold();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 17'h03000;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_pre_c_gnt got %b want 1", bus.c_gnt); end
    step();
    bus.h_hold = 1'b1;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_rise_c_gnt got %b want 0", bus.c_gnt); end
    n_checks++; if (bus.c_rvalid !== 1'b1) begin n_fail++; $display("FAIL hold_rise_c_rvalid got %b want 1", bus.c_rvalid); end
    n_checks++; if (bus.h_own !== 1'b0) begin n_fail++; $display("FAIL hold_rise_h_own got %b want 0", bus.h_own); end
    n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL hold_rise_stall got %b want 1", bus.core_stall); end
    step();
    for (int i = 0; i < 16; i++) begin
      bus.h_req = 1'b1; bus.h_we = 1'b1;
      bus.h_addr = 17'h01400 + 17'(i); bus.h_wdata = 8'h40 + 8'(i);
      #1;
      n_checks++; if (bus.h_own !== 1'b1) begin n_fail++; $display("FAIL hold_h_own cyc %0d got %b want 1", i, bus.h_own); end
      n_checks++; if ({bus.h_gnt, bus.c_gnt} !== 2'b10) begin n_fail++; $display("FAIL hold_gnt cyc %0d got %b want 10", i, {bus.h_gnt, bus.c_gnt}); end
      n_checks++; if (bus.m_addr !== 17'h01400 + 17'(i)) begin n_fail++; $display("FAIL hold_m_addr cyc %0d got %h want %h", i, bus.m_addr, 17'h01400 + 17'(i)); end
      if (i == 0) begin
        n_checks++; if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_c_rvalid got %b want 0", bus.c_rvalid); end
      end
      step();
    end
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_hold = 1'b0;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_drop_c_gnt got %b want 0", bus.c_gnt); end
    n_checks++; if (bus.h_own !== 1'b1) begin n_fail++; $display("FAIL hold_drop_h_own got %b want 1", bus.h_own); end
    step();
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_resume_c_gnt got %b want 1", bus.c_gnt); end
    n_checks++; if (bus.h_own !== 1'b0) begin n_fail++; $display("FAIL hold_resume_h_own got %b want 0", bus.h_own); end
    step();
    bus.c_addr = 17'h01405;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL hold_readback_gnt got %b want 1", bus.c_gnt); end
    step();
    bus.c_req = 1'b0;
    #1;
    n_checks++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 8'h45}) begin n_fail++; $display("FAIL hold_readback got %b/%h want 1/45", bus.c_rvalid, bus.c_rdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_hold_idle();
    bus.h_hold = 1'b1;
    #1;
    n_checks++; if (bus.m_cs !== 1'b0) begin n_fail++; $display("FAIL hidle_m_cs0 got %b want 0", bus.m_cs); end
    step();
    bus.h_hold = 1'b0;
    #1;
    n_checks++; if (bus.h_own !== 1'b1) begin n_fail++; $display("FAIL hidle_h_own got %b want 1", bus.h_own); end
    n_checks++; if (bus.m_cs !== 1'b0) begin n_fail++; $display("FAIL hidle_m_cs1 got %b want 0", bus.m_cs); end
    step();
    n_checks++; if (bus.h_own !== 1'b0) begin n_fail++; $display("FAIL hidle_h_own_drop got %b want 0", bus.h_own); end
  endtask

  task automatic test_write_read();
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 17'h02000; bus.h_wdata = 8'hA5;
    #1;
    n_checks++; if (bus.h_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_h_gnt got %b want 1", bus.h_gnt); end
    n_checks++; if ({bus.m_we, bus.m_wdata, bus.m_addr} !== {1'b1, 8'hA5, 17'h02000}) begin n_fail++; $display("FAIL wr_m_bus got %b/%h/%h want 1/a5/02000", bus.m_we, bus.m_wdata, bus.m_addr); end
    step();
    bus.h_req = 1'b0; bus.h_we = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 17'h02000;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_c_gnt got %b want 1", bus.c_gnt); end
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 0", bus.h_rvalid); end
    step();
    bus.c_req = 1'b0;
    #1;
    n_checks++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL rd_after_wr got %b/%h want 1/a5", bus.c_rvalid, bus.c_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.c_req = 1'b1; bus.c_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.c_addr = 17'h01400 + 17'(i);
      if (i == 4) bus.c_req = 1'b0;
      #1;
      if (i < 4) begin
        n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt cyc %0d got %b want 1", i, bus.c_gnt); end
      end
      if (i > 0) begin
        n_checks++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 8'h40 + 8'(i - 1)}) begin n_fail++; $display("FAIL b2b_rdata cyc %0d got %b/%h want 1/%h", i, bus.c_rvalid, bus.c_rdata, 8'h40 + 8'(i - 1)); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 17'h02000;
    #1;
    n_checks++; if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_c_gnt got %b want 1", bus.c_gnt); end
    @(posedge clk);
    rst = 1'b1;
    bus.c_req = 1'b0;
    #1;
    n_checks++; if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_c_rvalid got %b want 0", bus.c_rvalid); end
    #2;
    rst = 1'b0;
    step();
    // Build up burst credit, then reset while a hold-cycle host read is in flight
    bus.c_req = 1'b1; bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 17'h00020;
    step(); step(); step();
    bus.h_hold = 1'b1;
    #1;
    n_checks++; if (bus.h_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_h_gnt got %b want 1", bus.h_gnt); end
    @(posedge clk);
    rst = 1'b1;
    bus.h_hold = 1'b0;
    #1;
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_h_rvalid got %b want 0", bus.h_rvalid); end
    n_checks++; if (bus.h_own !== 1'b0) begin n_fail++; $display("FAIL rmid_h_own got %b want 0", bus.h_own); end
    n_checks++; if (bus.m_cs !== 1'b0) begin n_fail++; $display("FAIL rmid_m_cs got %b want 0", bus.m_cs); end
    #3;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic exp_c;
      exp_c = (i == 4);
      #1;
      n_checks++; if ({bus.c_gnt, bus.h_gnt} !== {exp_c, !exp_c}) begin n_fail++; $display("FAIL rmid_burst slot %0d got %b want %b", i, {bus.c_gnt, bus.h_gnt}, {exp_c, !exp_c}); end
      @(posedge clk);
    end
    #1;
    idle_inputs();
    step();
  endtask

  initial begin
    mem[17'h01000] = 8'h5A;
    idle_inputs();
    #12;
    test_reset();
    test_core_read();
    test_contention();
    test_hold();
    test_hold_idle();
    test_write_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
